// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: sequential Y86-64 fetch stage with a writable byte-wide
// instruction memory and a registered valid/ready record to decode.
// Optional build macro: Y86_FETCH_BRANCH_PREDICT_EN (jXX/call predicted taken,
// ret stalls fetch until a redirect arrives).
module y86_fetch_unit #(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       IMEM_BYTES = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [7:0]        imem_wdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pc_out,
    output logic [2:0]        stat,
    output logic              pred_taken
);

    localparam int unsigned     IDX_W   = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(IMEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_ERR
    } state_e;

    logic [7:0]        imem_q [IMEM_BYTES];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        icode_q, icode_d;
    logic [3:0]        ifun_q, ifun_d;
    logic [3:0]        ra_q, ra_d;
    logic [3:0]        rb_q, rb_d;
    logic [63:0]       valc_q, valc_d;
    logic [ADDR_W-1:0] valp_q, valp_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [2:0]        stat_q, stat_d;

    logic [7:0]        fbyte [10];
    logic [3:0]        dec_icode, dec_ifun, dec_ra, dec_rb;
    logic [63:0]       dec_valc;
    logic [ADDR_W-1:0] dec_valp;
    logic [2:0]        dec_stat;
    logic [3:0]        dec_len;
    logic              need_reg, need_valc, dec_ins, dec_adr;
    logic [ADDR_W:0]   valp_full, last_byte;
    logic [ADDR_W-1:0] next_pc;
    logic              fetch_block;

    // Synchronous byte write; addresses outside the array are dropped.
    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < MEM_LIM)) begin
            imem_q[imem_waddr[IDX_W-1:0]] <= imem_wdata;
        end
    end

    // Ten-byte fetch window at pc; bytes past the array (or past 2^ADDR_W) read 0.
    always_comb begin
        logic [ADDR_W:0] addr;
        for (int unsigned k = 0; k < 10; k++) begin
            addr     = {1'b0, pc_q} + (ADDR_W + 1)'(k);
            fbyte[k] = (addr < MEM_LIM) ? imem_q[addr[IDX_W-1:0]] : 8'h00;
        end
    end

    // Instruction decode: length, fields, constant, valP and status.
    always_comb begin
        dec_icode = fbyte[0][7:4];
        dec_ifun  = fbyte[0][3:0];
        need_reg  = 1'b0;
        need_valc = 1'b0;
        dec_len   = 4'd1;
        dec_ins   = 1'b0;
        case (dec_icode)
            4'h0, 4'h1, 4'h9: begin
                dec_ins = (dec_ifun != 4'h0);
            end
            4'h2: begin
                need_reg = 1'b1;
                dec_len  = 4'd2;
                dec_ins  = (dec_ifun > 4'h6);
            end
            4'h3, 4'h4, 4'h5: begin
                need_reg  = 1'b1;
                need_valc = 1'b1;
                dec_len   = 4'd10;
                dec_ins   = (dec_ifun != 4'h0);
            end
            4'h6: begin
                need_reg = 1'b1;
                dec_len  = 4'd2;
                dec_ins  = (dec_ifun > 4'h3);
            end
            4'h7: begin
                need_valc = 1'b1;
                dec_len   = 4'd9;
                dec_ins   = (dec_ifun > 4'h6);
            end
            4'h8: begin
                need_valc = 1'b1;
                dec_len   = 4'd9;
                dec_ins   = (dec_ifun != 4'h0);
            end
            4'hA, 4'hB: begin
                need_reg = 1'b1;
                dec_len  = 4'd2;
                dec_ins  = (dec_ifun != 4'h0);
            end
            default: begin
                dec_ins = 1'b1;
            end
        endcase

        dec_ra = need_reg ? fbyte[1][7:4] : 4'hF;
        dec_rb = need_reg ? fbyte[1][3:0] : 4'hF;

        dec_valc = '0;
        if (need_valc) begin
            for (int unsigned j = 0; j < 8; j++) begin
                dec_valc[8*j +: 8] = need_reg ? fbyte[j + 2] : fbyte[j + 1];
            end
        end

        valp_full = {1'b0, pc_q} + (ADDR_W + 1)'(dec_len);
        last_byte = valp_full - (ADDR_W + 1)'(1);
        dec_valp  = valp_full[ADDR_W-1:0];
        dec_adr   = valp_full[ADDR_W] || (last_byte >= MEM_LIM);

        if (dec_ins) begin
            dec_stat = STAT_INS;
        end else if (dec_adr) begin
            dec_stat = STAT_ADR;
        end else if (dec_icode == 4'h0) begin
            dec_stat = STAT_HLT;
        end else begin
            dec_stat = STAT_AOK;
        end
    end

`ifdef Y86_FETCH_BRANCH_PREDICT_EN
    logic pred_d;
    logic pred_taken_q, pred_taken_d;
    logic ret_wait_q, ret_wait_d;

    // Static predictor: jumps and calls continue at their constant target.
    always_comb begin
        pred_d  = (dec_icode == 4'h7) || (dec_icode == 4'h8);
        next_pc = pred_d ? ADDR_W'(dec_valc) : dec_valp;
    end

    assign pred_taken = pred_taken_q;
`else
    assign next_pc    = dec_valp;
    assign pred_taken = 1'b0;
`endif

    // Next-state: redirect beats fetch; fetch only when the output slot frees.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        valc_d      = valc_q;
        valp_d      = valp_q;
        pc_out_d    = pc_out_q;
        stat_d      = stat_q;
`ifdef Y86_FETCH_BRANCH_PREDICT_EN
        pred_taken_d = pred_taken_q;
        ret_wait_d   = ret_wait_q;
        fetch_block  = ret_wait_q;
`else
        fetch_block  = 1'b0;
`endif
        if ((state_q == ST_RUN) && redirect_valid) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
`ifdef Y86_FETCH_BRANCH_PREDICT_EN
            ret_wait_d  = 1'b0;
`endif
        end else if ((state_q == ST_RUN) && !fetch_block && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b1;
            icode_d     = dec_icode;
            ifun_d      = dec_ifun;
            ra_d        = dec_ra;
            rb_d        = dec_rb;
            valc_d      = dec_valc;
            valp_d      = dec_valp;
            pc_out_d    = pc_q;
            stat_d      = dec_stat;
            pc_d        = next_pc;
`ifdef Y86_FETCH_BRANCH_PREDICT_EN
            pred_taken_d = pred_d;
            ret_wait_d   = (dec_icode == 4'h9) && (dec_stat == STAT_AOK);
`endif
            case (dec_stat)
                STAT_HLT:           state_d = ST_HALT;
                STAT_ADR, STAT_INS: state_d = ST_ERR;
                default:            state_d = ST_RUN;
            endcase
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, PC and output record registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            icode_q     <= 4'h0;
            ifun_q      <= 4'h0;
            ra_q        <= 4'hF;
            rb_q        <= 4'hF;
            valc_q      <= '0;
            valp_q      <= '0;
            pc_out_q    <= '0;
            stat_q      <= STAT_AOK;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            valc_q      <= valc_d;
            valp_q      <= valp_d;
            pc_out_q    <= pc_out_d;
            stat_q      <= stat_d;
        end
    end

`ifdef Y86_FETCH_BRANCH_PREDICT_EN
    // Predictor-only state: taken flag of the record and the ret stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_taken_q <= 1'b0;
            ret_wait_q   <= 1'b0;
        end else begin
            pred_taken_q <= pred_taken_d;
            ret_wait_q   <= ret_wait_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign pc_out    = pc_out_q;
    assign stat      = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb_y86_fetch_unit: directed bench for y86_fetch_unit with an expected-record queue.
module tb_y86_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc_out;
    logic [2:0]  stat;
    logic        pred_taken;

    y86_fetch_unit #(
        .ADDR_W     (64),
        .IMEM_BYTES (1024),
        .RESET_PC   (64'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .icode          (icode),
        .ifun           (ifun),
        .rA             (rA),
        .rB             (rB),
        .valC           (valC),
        .valP           (valP),
        .pc_out         (pc_out),
        .stat           (stat),
        .pred_taken     (pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
        logic        pred;
    } rec_t;

    rec_t        exp_q [$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

`ifdef Y86_FETCH_BRANCH_PREDICT_EN
    localparam logic PRED_EN = 1'b1;
`else
    localparam logic PRED_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                                input logic [63:0] vp, input logic [2:0] st, input logic pr);
        rec_t r;
        r.pc = pc; r.icode = ic; r.ifun = fn; r.ra = ra; r.rb = rb;
        r.valc = vc; r.valp = vp; r.stat = st; r.pred = pr;
        return r;
    endfunction

    // Records handed to decode are compared against the head of the queue.
    always @(negedge clk) begin
        rec_t e;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("icode", 64'(icode), 64'(e.icode));
                chk("ifun", 64'(ifun), 64'(e.ifun));
                chk("rA", 64'(rA), 64'(e.ra));
                chk("rB", 64'(rB), 64'(e.rb));
                chk("valC", valC, e.valc);
                chk("valP", valP, e.valp);
                chk("stat", 64'(stat), 64'(e.stat));
                chk("pred_taken", 64'(pred_taken), 64'(e.pred));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic start_reset();
        rst = 1'b1;
        tick();
    endtask

    task automatic drain(input int unsigned max_cycles);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic idle_check(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            tick();
            chk("idle_out_valid", 64'(out_valid), 64'd0);
        end
    endtask

    task automatic held_check(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_pc_out"}, pc_out, 64'd0);
        chk({tag, "_icode"}, 64'(icode), 64'h2);
        chk({tag, "_rA"}, 64'(rA), 64'h4);
        chk({tag, "_rB"}, 64'(rB), 64'h5);
        chk({tag, "_valP"}, valP, 64'd2);
        chk({tag, "_stat"}, 64'(stat), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst            = 1'b1;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        tick();
        tick();

        // Reset values
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_ifun", 64'(ifun), 64'd0);
        chk("rst_rA", 64'(rA), 64'hF);
        chk("rst_rB", 64'(rB), 64'hF);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_pc_out", pc_out, 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_pred", 64'(pred_taken), 64'd0);

        // nop; halt
        wr(64'd0, 8'h10);
        wr(64'd1, 8'h00);
        exp_q.push_back(mk(64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 3'd1, 1'b0));
        exp_q.push_back(mk(64'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2, 3'd2, 1'b0));
        rst = 1'b0;
        drain(20);
        idle_check(5);

        // irmovq $0x0123456789ABCDEF, %rbx; halt
        start_reset();
        wr(64'd0, 8'h30); wr(64'd1, 8'hF3); wr(64'd2, 8'hEF); wr(64'd3, 8'hCD);
        wr(64'd4, 8'hAB); wr(64'd5, 8'h89); wr(64'd6, 8'h67); wr(64'd7, 8'h45);
        wr(64'd8, 8'h23); wr(64'd9, 8'h01); wr(64'd10, 8'h00);
        exp_q.push_back(mk(64'd0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'd10, 3'd1, 1'b0));
        exp_q.push_back(mk(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 3'd2, 1'b0));
        rst = 1'b0;
        drain(20);
        idle_check(2);
        rst = 1'b1;
        #2;
        chk("async_rst_stat", 64'(stat), 64'd1);
        chk("async_rst_rA", 64'(rA), 64'hF);
        chk("async_rst_pc_out", pc_out, 64'd0);

        // xorq %rcx,%rdx then bad OPq function 7
        start_reset();
        wr(64'd0, 8'h63); wr(64'd1, 8'h12); wr(64'd2, 8'h67); wr(64'd3, 8'h00);
        exp_q.push_back(mk(64'd0, 4'h6, 4'h3, 4'h1, 4'h2, 64'd0, 64'd2, 3'd1, 1'b0));
        exp_q.push_back(mk(64'd2, 4'h6, 4'h7, 4'h0, 4'h0, 64'd0, 64'd4, 3'd4, 1'b0));
        rst = 1'b0;
        drain(20);
        idle_check(3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd0;
        tick();
        redirect_valid = 1'b0;
        idle_check(3);

        // Redirect to an irmovq straddling the end of memory
        start_reset();
        out_ready = 1'b0;
        wr(64'd0, 8'h10);
        wr(64'd1024, 8'h55);
        wr(64'd1020, 8'h30); wr(64'd1021, 8'hF3); wr(64'd1022, 8'h11); wr(64'd1023, 8'h22);
        rst = 1'b0;
        tick();
        chk("pre_redirect_valid", 64'(out_valid), 64'd1);
        chk("pre_redirect_icode", 64'(icode), 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd1020;
        exp_q.push_back(mk(64'd1020, 4'h3, 4'h0, 4'hF, 4'h3, 64'h2211, 64'd1030, 3'd3, 1'b0));
        tick();
        chk("redirect_squash", 64'(out_valid), 64'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        drain(10);
        idle_check(3);

        // Back-pressure hold, then redirect during the stall
        start_reset();
        out_ready = 1'b0;
        wr(64'd0, 8'h20); wr(64'd1, 8'h45); wr(64'h40, 8'h00);
        rst = 1'b0;
        tick();
        held_check("hold1");
        tick();
        held_check("hold2");
        tick();
        held_check("hold3");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        tick();
        chk("stall_redirect_squash", 64'(out_valid), 64'd0);
        redirect_valid = 1'b0;
        exp_q.push_back(mk(64'h40, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 3'd2, 1'b0));
        out_ready = 1'b1;
        drain(10);
        idle_check(2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd0;
        tick();
        redirect_valid = 1'b0;
        idle_check(3);

        // jmp 0x20
        start_reset();
        wr(64'd0, 8'h70); wr(64'd1, 8'h20);
        for (int unsigned i = 2; i < 9; i++) wr(64'(i), 8'h00);
        wr(64'd9, 8'h00); wr(64'h20, 8'h00);
        exp_q.push_back(mk(64'd0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'd9, 3'd1, PRED_EN));
        if (PRED_EN) begin
            exp_q.push_back(mk(64'h20, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h21, 3'd2, 1'b0));
        end else begin
            exp_q.push_back(mk(64'd9, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd10, 3'd2, 1'b0));
        end
        rst = 1'b0;
        drain(20);
        idle_check(2);

        // ret
        start_reset();
        wr(64'd0, 8'h90); wr(64'd1, 8'h00); wr(64'h30, 8'h00);
        exp_q.push_back(mk(64'd0, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 3'd1, 1'b0));
        if (!PRED_EN) begin
            exp_q.push_back(mk(64'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2, 3'd2, 1'b0));
        end
        rst = 1'b0;
        drain(20);
        idle_check(4);
        if (PRED_EN) begin
            exp_q.push_back(mk(64'h30, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h31, 3'd2, 1'b0));
            redirect_valid = 1'b1;
            redirect_pc    = 64'h30;
            tick();
            redirect_valid = 1'b0;
            drain(10);
            idle_check(2);
        end

        // Same-cycle write to the fetched byte: fetch sees the old nop
        start_reset();
        wr(64'd0, 8'h10); wr(64'd1, 8'h00);
        exp_q.push_back(mk(64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 3'd1, 1'b0));
        exp_q.push_back(mk(64'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2, 3'd2, 1'b0));
        rst        = 1'b0;
        imem_we    = 1'b1;
        imem_waddr = 64'd0;
        imem_wdata = 8'hC0;
        tick();
        imem_we    = 1'b0;
        drain(20);
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
